// File: rtl/face_scan_sequencer.sv
// Face scan sequencer: averages a 3x3 grid of pixel windows over one frame,
// then walks the nine cell averages through an external colour classifier.
module face_scan_sequencer #(
    parameter int GRID_X0    = 160,
    parameter int GRID_Y0    = 80,
    parameter int CELL_PITCH = 106,
    parameter int WIN        = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Frame_Start,
    input  logic        Pix_Valid,
    input  logic [11:0] Pix_X,
    input  logic [11:0] Pix_Y,
    input  logic [29:0] Pix_RGB,
    output logic [29:0] Chk_Color,
    input  logic [29:0] Chk_Result,
    output logic [26:0] Face_Codes,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    localparam int LW = $clog2(WIN);
    localparam int SW = 10 + 2 * LW;
    localparam int CW = 2 * LW + 1;
    localparam logic [CW-1:0] FULL = CW'(WIN * WIN);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        ACCUM,
        CLASSIFY,
        FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sum_r_q [9];
    logic [SW-1:0] sum_r_d [9];
    logic [SW-1:0] sum_g_q [9];
    logic [SW-1:0] sum_g_d [9];
    logic [SW-1:0] sum_b_q [9];
    logic [SW-1:0] sum_b_d [9];
    logic [CW-1:0] cnt_q [9];
    logic [CW-1:0] cnt_d [9];
    logic [3:0]    k_q, k_d;
    logic          phase_q, phase_d;
    logic [29:0]   chk_color_q, chk_color_d;
    logic [26:0]   face_codes_q, face_codes_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic [29:0]   avg [9];
    logic [8:0]    hit;
    logic          all_full;
    logic          accum;
    logic          clr;
    logic [2:0]    code;

    function automatic logic in_win(input logic [11:0] p, input int lo);
        int v;
        v = int'({20'd0, p});
        return (v >= lo) && (v < lo + WIN);
    endfunction

    function automatic logic [2:0] encode(input logic [29:0] c);
        case (c)
            30'h3FF00000: return 3'd0;
            30'h000FFC00: return 3'd1;
            30'h000003FF: return 3'd2;
            30'h3FFFFC00: return 3'd3;
            30'h3FFFFFFF: return 3'd4;
            30'h3FFA5400: return 3'd5;
            default:      return 3'd7;
        endcase
    endfunction

    always_comb begin
        all_full = 1'b1;
        for (int k = 0; k < 9; k++) begin
            hit[k] = Pix_Valid
                   && in_win(Pix_X, GRID_X0 + (k % 3) * CELL_PITCH)
                   && in_win(Pix_Y, GRID_Y0 + (k / 3) * CELL_PITCH);
            avg[k] = {sum_r_q[k][SW-1 -: 10],
                      sum_g_q[k][SW-1 -: 10],
                      sum_b_q[k][SW-1 -: 10]};
            if (cnt_q[k] != FULL) all_full = 1'b0;
        end
    end

    assign code = encode(Chk_Result);

    always_comb begin
        state_d      = state_q;
        sum_r_d      = sum_r_q;
        sum_g_d      = sum_g_q;
        sum_b_d      = sum_b_q;
        cnt_d        = cnt_q;
        k_d          = k_q;
        phase_d      = phase_q;
        chk_color_d  = chk_color_q;
        face_codes_d = face_codes_q;
        error_d      = error_q;
        accum        = 1'b0;
        clr          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d      = WAIT_FRAME;
                    clr          = 1'b1;
                    error_d      = 1'b0;
                    face_codes_d = '0;
                end
            end
            WAIT_FRAME: begin
                if (Frame_Start) begin
                    state_d = ACCUM;
                    accum   = 1'b1;
                    clr     = 1'b1;
                end
            end
            ACCUM: begin
                if (all_full) begin
                    state_d     = CLASSIFY;
                    k_d         = 4'd0;
                    phase_d     = 1'b0;
                    chk_color_d = avg[0];
                end else begin
                    accum = 1'b1;
                    clr   = Frame_Start;
                end
            end
            CLASSIFY: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    for (int k = 0; k < 9; k++)
                        if (k_q == 4'(k)) face_codes_d[3*k +: 3] = code;
                    if (code == 3'd7) error_d = 1'b1;
                    if (k_q == 4'd8) begin
                        state_d     = FINISH;
                        chk_color_d = '0;
                    end else begin
                        k_d         = k_q + 4'd1;
                        phase_d     = 1'b0;
                        chk_color_d = avg[k_q + 4'd1];
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // saturating counters keep every channel sum within its width
        for (int k = 0; k < 9; k++) begin
            if (clr) begin
                sum_r_d[k] = '0;
                sum_g_d[k] = '0;
                sum_b_d[k] = '0;
                cnt_d[k]   = '0;
            end
            if (accum && hit[k] && cnt_d[k] != FULL) begin
                sum_r_d[k] = sum_r_d[k] + SW'(Pix_RGB[29:20]);
                sum_g_d[k] = sum_g_d[k] + SW'(Pix_RGB[19:10]);
                sum_b_d[k] = sum_b_d[k] + SW'(Pix_RGB[9:0]);
                cnt_d[k]   = cnt_d[k] + 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            sum_r_q      <= '{default: '0};
            sum_g_q      <= '{default: '0};
            sum_b_q      <= '{default: '0};
            cnt_q        <= '{default: '0};
            k_q          <= '0;
            phase_q      <= 1'b0;
            chk_color_q  <= '0;
            face_codes_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sum_r_q      <= sum_r_d;
            sum_g_q      <= sum_g_d;
            sum_b_q      <= sum_b_d;
            cnt_q        <= cnt_d;
            k_q          <= k_d;
            phase_q      <= phase_d;
            chk_color_q  <= chk_color_d;
            face_codes_q <= face_codes_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign Chk_Color  = chk_color_q;
    assign Face_Codes = face_codes_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Error      = error_q;

endmodule

// File: doc/face_scan_sequencer.md
FACE_SCAN_SEQUENCER -- requirements
Module: face_scan_sequencer

Interface
REQ-001 The block SHALL have parameter GRID_X0, default 160, giving the X of the left edge of cell column 0.
REQ-002 The block SHALL have parameter GRID_Y0, default 80, giving the Y of the top edge of cell row 0.
REQ-003 The block SHALL have parameter CELL_PITCH, default 106, giving the pixel spacing between adjacent cell origins in X and in Y.
REQ-004 The block SHALL have parameter WIN, default 8, giving the square sample window side; power of two, 2..16.
REQ-005 Port Clk, input, 1: the single clock; every register is clocked on its rising edge.
REQ-006 Port Reset, input, 1: synchronous, active-high reset.
REQ-007 Port Start, input, 1: one-cycle pulse requesting a face scan.
REQ-008 Port Frame_Start, input, 1: one-cycle pulse coincident with the first pixel of a frame.
REQ-009 Port Pix_Valid, input, 1: Pix_X, Pix_Y and Pix_RGB are valid this cycle.
REQ-010 Port Pix_X / Pix_Y, input, 12 each: coordinates of the current pixel.
REQ-011 Port Pix_RGB, input, 30: pixel colour, R[29:20], G[19:10], B[9:0].
REQ-012 Port Chk_Color, output, 30: averaged cell colour driven to the colour classifier.
REQ-013 Port Chk_Result, input, 30: classifier output, registered, valid one cycle after Chk_Color.
REQ-014 Port Face_Codes, output, 27: 3-bit code for cell k at bits [3k+2:3k], k = row*3 + col.
REQ-015 Port Busy, output, 1: high in every state other than IDLE.
REQ-016 Port Done, output, 1: one-cycle completion pulse.
REQ-017 Port Error, output, 1: sticky flag, set when at least one cell is unclassified.

Function
REQ-018 The FSM SHALL use states IDLE, WAIT_FRAME, ACCUM, CLASSIFY and FINISH.
REQ-019 IDLE -> WAIT_FRAME on Start; Start in any other state SHALL be ignored.
REQ-020 On the Start cycle, all nine accumulators, all pixel counters and Error SHALL be cleared.
REQ-021 WAIT_FRAME -> ACCUM on Frame_Start; that same pixel SHALL be eligible for accumulation.
REQ-022 Cell (r,c) window: X in [GRID_X0 + c*CELL_PITCH, + WIN-1] and Y in [GRID_Y0 + r*CELL_PITCH, + WIN-1], inclusive.
REQ-023 In ACCUM, a pixel with Pix_Valid=1 inside a window SHALL add R, G and B to that cell's three channel sums and increment that cell's counter.
REQ-024 Pixels outside all windows, or with Pix_Valid=0, SHALL be ignored.
REQ-025 Each channel sum SHALL be 10 + 2*log2(WIN) bits wide and SHALL never overflow.
REQ-026 ACCUM -> CLASSIFY on the first cycle in which all nine counters equal WIN*WIN.
REQ-027 A Frame_Start received in ACCUM before completion SHALL clear all sums and counters, remain in ACCUM, and accumulate the new frame.
REQ-028 The average for each channel SHALL be sum >> (2*log2(WIN)), truncated, 10 bits.
REQ-029 CLASSIFY SHALL process cells k = 0..8 in order, taking 2 cycles per cell (18 cycles total).
REQ-030 Issue cycle: Chk_Color = average of cell k.
REQ-031 Capture cycle: Chk_Result SHALL be encoded into slot k of Face_Codes.
REQ-032 Chk_Color SHALL hold its value through the capture cycle.
REQ-033 Encoding: 0x3FF00000 -> 0 (red); 0x000FFC00 -> 1 (green); 0x000003FF -> 2 (blue); 0x3FFFFC00 -> 3 (yellow); 0x3FFFFFFF -> 4 (white); 0x3FFA5400 -> 5 (orange).
REQ-034 Any other Chk_Result value, including 0, SHALL encode to 7 and set Error.
REQ-035 After the capture of cell 8, CLASSIFY -> FINISH.
REQ-036 FINISH SHALL pulse Done for exactly one cycle, then -> IDLE.
REQ-037 Face_Codes and Error SHALL hold their values until the next accepted Start.
REQ-038 Chk_Color SHALL be 0 outside CLASSIFY.

Reset
REQ-039 While Reset=1 at a rising edge, the FSM SHALL enter IDLE and Face_Codes, Chk_Color, Busy, Done, Error, all sums and all counters SHALL be 0.
REQ-040 Reset SHALL override Start, Frame_Start and any scan in progress; a scan aborted mid-operation SHALL NOT produce a Done pulse.

Verification
REQ-041 Uniform frame, Pix_RGB=0x3FF00000, classifier model = identity, defaults -> Done 1 cycle, Face_Codes=0, Error=0, Busy high from the cycle after Start through the Done cycle.
REQ-042 Each cell filled with a distinct colour: cells 0-5 = red..orange, cells 6-8 = white -> Face_Codes = {4,4,4,5,4,3,2,1,0} (slot 8..0), Error=0.
REQ-043 Cell 4 pixels alternate 0x3FF00000 / 0x000003FF -> Chk_Color for k=4 = 0x1FF001FF; classifier returns 0 -> slot 4 = 7, Error=1.
REQ-044 Frame_Start reasserted after 30 of cell 8's pixels -> no Done in the first frame; the second full frame completes with correct codes.
REQ-045 Reset asserted in the 5th CLASSIFY cycle -> all outputs 0 next cycle, no Done; a subsequent Start runs a normal scan.
REQ-046 Start pulsed during ACCUM and Pix_Valid=0 on window pixels -> the Start is ignored, the gated pixels are not counted, and completion waits for valid pixels.
